// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM state encoding, next-PC select
// encodings and the default reset PC.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_ERR   = 2'b11
  } fetch_state_t;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_J   = 2'b11
  } pcsrc_t;

endpackage

// File: rtl/npc_mux.sv
// Stateless next-PC selection: sequential, branch, register jump or
// pseudo-direct jump target, all mod 2^32.
module npc_mux (
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_pcsrc,
  input  logic [31:0] i_imm_ext,
  input  logic [31:0] i_rs_data,
  input  logic [25:0] i_jidx,
  output logic [31:0] o_pc4,
  output logic [31:0] o_npc
);
  import cpu_pkg::*;

  logic [31:0] w_pc4;

  assign w_pc4 = i_pc + 32'd4;
  assign o_pc4 = w_pc4;

  always_comb begin
    o_npc = w_pc4;
    case (pcsrc_t'(i_pcsrc))
      PCSRC_BR: o_npc = w_pc4 + (i_imm_ext << 2);
      PCSRC_JR: o_npc = i_rs_data;
      PCSRC_J:  o_npc = {w_pc4[31:28], i_jidx, 2'b00};
      default:  o_npc = w_pc4;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: owns the PC, issues instruction memory reads, holds
// the fetched word until execute retires it, and traps misaligned jr targets.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Pcsrc,
  input  logic [31:0] Imm_ext,
  input  logic [31:0] Rs_data,
  input  logic        Exec_done,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Inst,
  output logic        Inst_valid,
  output logic [31:0] Pc,
  output logic [31:0] Pc4,
  output logic        Addr_err,
  output logic [31:0] Inst_cnt
);
  import cpu_pkg::*;

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic [31:0]  r_inst_cnt;
  logic         r_inst_valid;
  logic         r_addr_err;
  logic         r_imem_req;

  logic [31:0]  w_npc;
  logic [31:0]  w_pc4;
  logic         w_jr_misaligned;

  npc_mux u_npc_mux (
    .i_pc      (r_pc),
    .i_pcsrc   (Pcsrc),
    .i_imm_ext (Imm_ext),
    .i_rs_data (Rs_data),
    .i_jidx    (r_inst[25:0]),
    .o_pc4     (w_pc4),
    .o_npc     (w_npc)
  );

  assign w_jr_misaligned = (pcsrc_t'(Pcsrc) == PCSRC_JR) && (Rs_data[1:0] != 2'b00);

  // Imem_req is registered alongside the state so it is high exactly in FETCH.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= 32'd0;
      r_inst_valid <= 1'b0;
      r_addr_err   <= 1'b0;
      r_inst_cnt   <= 32'd0;
      r_imem_req   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (Imem_ack) begin
            r_inst       <= Imem_rdata;
            r_inst_valid <= 1'b1;
            r_imem_req   <= 1'b0;
            r_state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (Exec_done) begin
            r_inst_valid <= 1'b0;
            if (w_jr_misaligned) begin
              r_addr_err <= 1'b1;
              r_state    <= ST_ERR;
            end else begin
              r_pc       <= w_npc;
              r_inst_cnt <= r_inst_cnt + 32'd1;
              r_imem_req <= 1'b1;
              r_state    <= ST_FETCH;
            end
          end
        end
        ST_ERR: begin
          r_imem_req <= 1'b0;
          r_addr_err <= 1'b1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign Imem_req   = r_imem_req;
  assign Imem_addr  = r_pc;
  assign Inst       = r_inst;
  assign Inst_valid = r_inst_valid;
  assign Pc         = r_pc;
  assign Pc4        = w_pc4;
  assign Addr_err   = r_addr_err;
  assign Inst_cnt   = r_inst_cnt;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port Pcsrc, input, 2: next-PC select from the control unit; 00 PC+4, 01 branch, 10 jr, 11 j/jal.
REQ-005 SHALL have port Imm_ext, input, 32: sign-extended 16-bit immediate, used as the branch offset.
REQ-006 SHALL have port Rs_data, input, 32: register rs value, used as the jr target.
REQ-007 SHALL have port Exec_done, input, 1: the execute side has finished the current instruction, and Pcsrc/Rs_data are valid.
REQ-008 SHALL have port Imem_req, output, 1: instruction memory read request.
REQ-009 SHALL have port Imem_addr, output, 32: instruction memory read address, always equal to Pc.
REQ-010 SHALL have port Imem_ack, input, 1: read data valid this cycle.
REQ-011 SHALL have port Imem_rdata, input, 32: instruction word.
REQ-012 SHALL have port Inst, output, 32: registered instruction feeding the Op/Func decode.
REQ-013 SHALL have port Inst_valid, output, 1: Inst holds a fetched instruction awaiting execution.
REQ-014 SHALL have port Pc, output, 32: address of Inst.
REQ-015 SHALL have port Pc4, output, 32: Pc+4, combinational, used as the jal link value.
REQ-016 SHALL have port Addr_err, output, 1: sticky misaligned-jr flag.
REQ-017 SHALL have port Inst_cnt, output, 32: retired-instruction counter.

Function
REQ-018 SHALL implement a four-state FSM: IDLE, FETCH, HOLD, ERR.
REQ-019 SHALL move from IDLE to FETCH on the first clock edge after Reset deasserts.
REQ-020 SHALL drive Imem_req=1 only in FETCH, with Imem_addr held stable until Imem_ack is sampled high.
REQ-021 SHALL, in FETCH with Imem_ack=1, capture Imem_rdata into Inst, set Inst_valid=1 and enter HOLD; an ack in the first FETCH cycle (zero wait) SHALL be accepted.
REQ-022 SHALL ignore Imem_ack outside FETCH and ignore Exec_done outside HOLD.
REQ-023 SHALL, in HOLD with Exec_done=1, load Pc with the next PC, clear Inst_valid, increment Inst_cnt and enter FETCH on the same edge.
REQ-024 SHALL compute the next PC, mod 2^32, as: 00 Pc+4; 01 Pc+4+(Imm_ext<<2); 10 Rs_data; 11 {Pc4[31:28], Inst[25:0], 2'b00}.
REQ-025 SHALL wrap Pc=32'hFFFF_FFFC with Pcsrc=00 to 32'h0000_0000 without error.
REQ-026 SHALL, in HOLD with Exec_done=1, Pcsrc=10 and Rs_data[1:0]!=0, enter ERR, set Addr_err=1, hold Pc and Inst_cnt unchanged, and clear Inst_valid.
REQ-027 SHALL keep ERR, with Imem_req=0 and Addr_err=1, until Reset.
REQ-028 SHALL wrap Inst_cnt from 32'hFFFF_FFFF to 0.

Reset
REQ-029 SHALL, while Reset=1, force state=IDLE, Pc=RESET_PC, Inst=0, Inst_valid=0, Addr_err=0, Inst_cnt=0 and Imem_req=0, irrespective of Clk.
REQ-030 SHALL abandon any outstanding fetch on Reset mid-FETCH; a late Imem_ack in IDLE SHALL be ignored.

Structure
REQ-031 SHALL take the FSM state encoding, the Pcsrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_JR, PCSRC_J) and the default RESET_PC from a shared package, cpu_pkg.
REQ-032 SHALL place the next-PC computation in one combinational sub-module, npc_mux, which holds no state.

Verification
REQ-033 Reset, then Imem_ack=1 on the 3rd FETCH cycle with rdata=32'h2008_0005 -> Imem_addr=0 held for 3 cycles; Inst=32'h2008_0005, Inst_valid=1 next cycle.
REQ-034 Pc=32'h0000_0010, Pcsrc=01, Imm_ext=32'hFFFF_FFFE, Exec_done -> Pc=32'h0000_000C, Inst_cnt+1.
REQ-035 Pc=32'h0040_0000, Inst=32'h0C00_0100 (jal), Pcsrc=11, Exec_done -> Pc=32'h0000_0400; Pc4=32'h0040_0004 during HOLD.
REQ-036 Pcsrc=10, Rs_data=32'h0000_1002, Exec_done -> ERR, Addr_err=1, Pc unchanged, Imem_req stays 0 thereafter.
REQ-037 Reset pulsed mid-FETCH, then ack during IDLE -> all outputs at reset values and the ack ignored; the next FETCH is from RESET_PC.
REQ-038 Pc=32'hFFFF_FFFC, Pcsrc=00, Exec_done -> Pc=0, Addr_err=0.
